// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives every input combination into a combinational
// block under test, captures its single output per row into a truth table,
// then compares against an expected table latched at start.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        run request, accepted only when idle
//   expected     expected table, bit i = output for input value i
//   dut_out      output of the block under test
//   drive        inputs to the block under test (MSB = A)
//   busy         high while a run is in progress
//   done         one-cycle pulse when results become valid
//   pass         captured table equals expected table
//   fail_idx     lowest mismatching row (0 when pass)
//   err_cnt      number of mismatching rows
//   table_out    captured truth table
module truth_table_scanner #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      drive,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN-1:0]      fail_idx,
  output logic [N_IN:0]        err_cnt,
  output logic [2**N_IN-1:0]   table_out
);

  localparam int unsigned     ROWS     = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_ROW = N_IN'(ROWS - 1);
  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [ROWS-1:0]   exp_q;

  logic [ROWS-1:0]   diff;
  logic [N_IN:0]     diff_cnt;
  logic [N_IN-1:0]   diff_low;

  // Mismatch statistics; scanning high to low leaves the lowest set index.
  always_comb begin
    diff     = table_out ^ exp_q;
    diff_cnt = '0;
    diff_low = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (diff[i]) begin
        diff_cnt = diff_cnt + (N_IN+1)'(1);
        diff_low = N_IN'(i);
      end
    end
  end

  // Scan controller with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      exp_q     <= '0;
      drive     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_idx  <= '0;
      err_cnt   <= '0;
      table_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            exp_q     <= expected;
            table_out <= '0;
            pass      <= 1'b0;
            fail_idx  <= '0;
            err_cnt   <= '0;
            drive     <= '0;
            wait_cnt  <= SETTLE_W;
            busy      <= 1'b1;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // Sample on the last edge of this row's window.
            table_out[drive] <= dut_out;
            if (drive == LAST_ROW) begin
              state <= S_DONE;
            end else begin
              drive    <= drive + N_IN'(1);
              wait_cnt <= SETTLE_W;
            end
          end
        end
        S_DONE: begin
          pass     <= (diff == '0);
          err_cnt  <= diff_cnt;
          fail_idx <= diff_low;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: one instance with SETTLE=0
// and one with SETTLE=2, each driving a selectable combinational block.
module tb_truth_table_scanner;

  localparam int R = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b;
  logic [7:0] exp_a, exp_b;
  logic       dut_a, dut_b;
  logic [2:0] drive_a, drive_b, fail_a, fail_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [3:0] err_a, err_b;
  logic [7:0] tab_a, tab_b;

  int         mode_a, mode_b;
  logic [7:0] tbl_a, tbl_b;
  int         tests = 0;
  int         fails = 0;

  truth_table_scanner u_a (
    .clk(clk), .reset(reset), .start(start_a), .expected(exp_a), .dut_out(dut_a),
    .drive(drive_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_idx(fail_a), .err_cnt(err_a), .table_out(tab_a)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(2)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .expected(exp_b), .dut_out(dut_b),
    .drive(drive_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_idx(fail_b), .err_cnt(err_b), .table_out(tab_b)
  );

  // Blocks under test: 0 parity, 1 AND3, 2 constant 1, other = lookup table.
  function automatic logic blk(input int m, input logic [7:0] t, input logic [2:0] v);
    case (m)
      0:       return ^v;
      1:       return &v;
      2:       return 1'b1;
      default: return t[v];
    endcase
  endfunction

  always_comb dut_a = blk(mode_a, tbl_a, drive_a);
  always_comb dut_b = blk(mode_b, tbl_b, drive_b);

  int         sel;
  logic [2:0] m_drive, m_fail;
  logic       m_busy, m_done, m_pass;
  logic [3:0] m_err;
  logic [7:0] m_tab;

  always_comb begin
    if (sel == 0) begin
      m_drive = drive_a; m_fail = fail_a; m_busy = busy_a; m_done = done_a;
      m_pass = pass_a; m_err = err_a; m_tab = tab_a;
    end else begin
      m_drive = drive_b; m_fail = fail_b; m_busy = busy_b; m_done = done_b;
      m_pass = pass_b; m_err = err_b; m_tab = tab_b;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_exp(input int s, input logic [7:0] v);
    if (s == 0) exp_a = v; else exp_b = v;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_drive"}, 32'(m_drive), 0);
    chk({tag, "_busy"},  32'(m_busy),  0);
    chk({tag, "_done"},  32'(m_done),  0);
    chk({tag, "_pass"},  32'(m_pass),  0);
    chk({tag, "_fail"},  32'(m_fail),  0);
    chk({tag, "_err"},   32'(m_err),   0);
    chk({tag, "_tab"},   32'(m_tab),   0);
  endtask

  // One full run with expected timing and results derived from the rules.
  task automatic run(input string tag, input int s, input int m, input logic [7:0] tbl,
                     input logic [7:0] expv, input bit pre, input bit glitch,
                     input bit chain, input logic [7:0] nexp);
    int st, lat, dexp;
    logic [7:0] tab, diff;
    int cnt, low;
    st  = (s == 0) ? 0 : 2;
    lat = R * (st + 1) + 1;
    cnt = 0;
    low = 0;
    for (int v = 0; v < R; v++) tab[v] = blk(m, tbl, 3'(v));
    diff = tab ^ expv;
    for (int v = R - 1; v >= 0; v--) if (diff[v]) begin cnt++; low = v; end
    sel = s;
    if (s == 0) begin mode_a = m; tbl_a = tbl; end
    else        begin mode_b = m; tbl_b = tbl; end
    if (!pre) begin set_exp(s, expv); set_start(s, 1'b1); end
    @(posedge clk); #1;
    set_start(s, 1'b0);
    chk({tag, "_c0_drive"}, 32'(m_drive), 0);
    chk({tag, "_c0_busy"},  32'(m_busy),  1);
    chk({tag, "_c0_done"},  32'(m_done),  0);
    chk({tag, "_c0_tab"},   32'(m_tab),   0);
    chk({tag, "_c0_pass"},  32'(m_pass),  0);
    chk({tag, "_c0_err"},   32'(m_err),   0);
    if (glitch) set_exp(s, ~expv);
    for (int c = 1; c <= lat + 1; c++) begin
      set_start(s, glitch && (c == 3));
      @(posedge clk); #1;
      dexp = c / (st + 1);
      if (dexp > R - 1) dexp = R - 1;
      chk($sformatf("%s_c%0d_drive", tag, c), 32'(m_drive), 32'(dexp));
      if (c < lat) begin
        chk($sformatf("%s_c%0d_busy", tag, c), 32'(m_busy), 1);
        chk($sformatf("%s_c%0d_done", tag, c), 32'(m_done), 0);
      end else begin
        chk($sformatf("%s_c%0d_done", tag, c), 32'(m_done), (c == lat) ? 1 : 0);
        chk($sformatf("%s_c%0d_busy", tag, c), 32'(m_busy), 0);
        chk($sformatf("%s_c%0d_tab",  tag, c), 32'(m_tab),  32'(tab));
        chk($sformatf("%s_c%0d_pass", tag, c), 32'(m_pass), (cnt == 0) ? 1 : 0);
        chk($sformatf("%s_c%0d_err",  tag, c), 32'(m_err),  32'(cnt));
        chk($sformatf("%s_c%0d_fail", tag, c), 32'(m_fail), 32'(low));
        if (chain && c == lat) begin
          set_start(s, 1'b1);
          set_exp(s, nexp);
          return;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; start_a = 0; start_b = 0; exp_a = 0; exp_b = 0;
    mode_a = 0; mode_b = 0; tbl_a = 0; tbl_b = 0; sel = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sel = 0; #0 chk_zero("rst_a");
    sel = 1; #0 chk_zero("rst_b");

    run("parity",   0, 0, 8'h00, 8'h96, 0, 0, 0, 8'h00);
    run("mism",     0, 0, 8'h00, 8'h97, 0, 0, 0, 8'h00);
    run("and3",     0, 1, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    run("const1s2", 1, 2, 8'h00, 8'h00, 0, 0, 0, 8'h00);
    run("glitch",   0, 0, 8'h00, 8'h96, 0, 1, 0, 8'h00);
    run("chain1",   0, 0, 8'h00, 8'h96, 0, 0, 1, 8'h80);
    run("chain2",   0, 1, 8'h00, 8'h80, 1, 0, 0, 8'h00);

    // Reset sampled at edge k+4 aborts the run.
    sel = 0; mode_a = 0; exp_a = 8'h96; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero("abort");
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_nodone%0d", c), 32'(done_a), 0);
      chk($sformatf("abort_idle%0d", c),   32'(busy_a), 0);
    end
    run("after_rst", 0, 0, 8'h00, 8'h96, 0, 0, 0, 8'h00);

    for (int i = 0; i < 10; i++) begin
      logic [7:0] t, e;
      int s;
      t = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       e = t;
        1:       e = t ^ (8'h01 << $urandom_range(0, 7));
        default: e = 8'($urandom);
      endcase
      s = int'($urandom_range(0, 1));
      run($sformatf("rnd%0d", i), s, 3, t, e, 0, 0, 0, 8'h00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential stimulus/response engine for the combinational NAND-built expression blocks: it drives every input combination into a combinational block under test, samples that block's single output, and assembles the full truth table. It compares the table against an expected table and reports pass/fail, the first failing row, and the mismatch count. It is the driving and checking end of the combinational blocks' A/B/C→out interface and replaces hand-written stimulus sequences in benches and on-chip self-test.

## Interface
Parameters:
- N_IN, 3: input width of the block under test; the table has 2**N_IN rows.
- SETTLE, 0: extra wait cycles per row before sampling; range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  run request; accepted only in IDLE.
- expected  in  2**N_IN  expected table, bit i = output for input value i.
- dut_out  in  1  output of the block under test.
- drive  out  N_IN  inputs to the block under test; drive[N_IN-1] is A (MSB), drive[0] is C (LSB) for N_IN=3.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when results become valid.
- pass  out  1  table_out == expected-at-start.
- fail_idx  out  N_IN  lowest mismatching row; 0 when pass=1.
- err_cnt  out  N_IN+1  number of mismatching rows, 0..2**N_IN.
- table_out  out  2**N_IN  captured truth table.

## Operation
- States: IDLE, RUN, DONE.
- Reset value of every output and register is 0, and the state is IDLE.
- IDLE, start=1:
  - latch expected into exp_q;
  - clear table_out, pass, fail_idx and err_cnt;
  - drive<=0, wait<=SETTLE, state<=RUN.
- RUN:
  - if wait!=0, decrement wait and hold drive;
  - otherwise table_out[drive]<=dut_out;
  - if drive==2**N_IN-1, go to DONE; otherwise drive<=drive+1 and wait<=SETTLE.
- DONE, single cycle:
  - diff = table_out ^ exp_q;
  - register pass<=(diff==0), err_cnt<=popcount(diff), fail_idx<=index of the lowest set bit of diff (0 if none);
  - done<=1, state<=IDLE.
- drive keeps its last value (all ones) after a run until the next start or reset.
- busy = (state != IDLE).
- done is cleared on the next cycle.
- start while busy is ignored, with no queueing.
- Changes to expected after acceptance have no effect.
- pass, fail_idx, err_cnt and table_out hold until the next accepted start or reset.
- Reset during RUN or DONE aborts the run with no done pulse. Every output returns to 0 on the edge where reset is sampled.

## Timing
- start is sampled at edge k.
- drive=0 and busy=1 are visible after edge k.
- Each row is presented for SETTLE+1 cycles. dut_out is sampled on the last edge of that window, so a row-i sample occurs at edge k+(i+1)(SETTLE+1).
- The last sample is at edge k+R(SETTLE+1), with R=2**N_IN.
- done=1, with pass, fail_idx and err_cnt valid, during the cycle after edge k+R(SETTLE+1)+1. busy=0 in that same cycle.
- Latency from start to done is R(SETTLE+1)+1 cycles, which is 9 for the defaults.
- A start asserted in the done cycle is accepted, giving back-to-back runs. Results are cleared on the next edge.
- dut_out must settle within SETTLE+1 cycles of a drive change. The block under test is purely combinational, so SETTLE=0 is sufficient.

## Test plan
- Parity: dut_out = ^drive, N_IN=3, SETTLE=0, expected=8'h96, start pulse at edge k.
  - drive steps 0..7 on edges k..k+7;
  - done at the cycle after edge k+9;
  - table_out=8'h96, pass=1, err_cnt=0, fail_idx=0.
- Single mismatch: same parity block, expected=8'h97.
  - pass=0, err_cnt=1, fail_idx=0, table_out=8'h96.
- AND3 vs all-zeros: dut_out = &drive, expected=8'h00.
  - table_out=8'h80, fail_idx=7, err_cnt=1.
- Constant 1 vs 8'h00, SETTLE=2.
  - err_cnt=8 (4'b1000), fail_idx=0;
  - each drive value is held 3 cycles;
  - done 25 cycles after start.
- Protocol edge cases:
  - start re-pulsed mid-run is ignored, and the run still completes at k+9;
  - expected changed mid-run has no effect on pass;
  - start in the done cycle launches a second run with busy continuous from that edge.
- Reset asserted at k+4:
  - all outputs read 0 on the next cycle, with no done pulse and state IDLE;
  - a following start produces a full correct run.
